// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage access unit.
// The FSM top and the lane formatter both import this package.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    localparam int RegDataWidth  = 32;
    localparam int ByteSlctWidth = RegDataWidth / 8;

    function automatic int byte_slct_width(input int data_w);
        return data_w / 8;
    endfunction

    // Natural alignment check on the three low address bits.
    function automatic logic is_aligned(input mem_size_e sz, input logic [2:0] low);
        logic ok;
        case (sz)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~low[0];
            SZ_WORD: ok = (low[1:0] == 2'b00);
            default: ok = (low == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle: request side driven by the access unit (master),
// completion side driven by the memory (slave).
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
// Sizes wider than DATA_W pass data through unmodified; the caller rejects them.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = $clog2(BE_W)
) (
    input  mem_size_e         size,
    input  logic [LANE_W-1:0] lane,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] mask;
    logic [BE_W-1:0]   be_base;
    logic              fill_bit;

    assign rd_shift = rd_data >> {lane, 3'b000};

    always_comb begin
        mask     = '1;
        be_base  = '1;
        fill_bit = 1'b0;
        case (size)
            SZ_BYTE: begin
                mask     = DATA_W'(8'hFF);
                be_base  = BE_W'(1'b1);
                fill_bit = rd_shift[7];
            end
            SZ_HALF: begin
                mask     = DATA_W'(16'hFFFF);
                be_base  = BE_W'(2'b11);
                fill_bit = rd_shift[15];
            end
            SZ_WORD: begin
                mask     = DATA_W'(32'hFFFF_FFFF);
                be_base  = BE_W'(4'hF);
                fill_bit = rd_shift[31];
            end
            default: begin
                mask     = '1;
                be_base  = '1;
                fill_bit = 1'b0;
            end
        endcase
    end

    assign be      = be_base << lane;
    assign wdata   = (st_data & mask) << {lane, 3'b000};
    assign ld_data = (rd_shift & mask) | ({DATA_W{fill_bit & sign_ext}} & ~mask);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: validates the op, issues a registered request to a
// variable-latency data memory, stalls until ack or timeout, formats loads.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              ReadMem,
    input  logic              WriteMem,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic              FWLS,
    input  logic [DATA_W-1:0] reg_data_2,
    input  logic [DATA_W-1:0] WB_data,
    mem_access_unit_if.master mem,
    output logic              stall,
    output logic [DATA_W-1:0] data_to_reg,
    output logic              load_valid,
    output logic              addr_err,
    output logic              bus_err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    mau_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] dtr_q, dtr_d;
    logic              lv_q, lv_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;
    mem_size_e         size_q, size_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic              sext_q, sext_d;

    mem_size_e         size_in;
    logic              one_op, any_op, size_ok, aligned, can_accept;
    logic              accept, illegal, timeout_hit;
    mem_size_e         fmt_size;
    logic [LANE_W-1:0] fmt_lane;
    logic              fmt_sext;
    logic [DATA_W-1:0] st_data;
    logic [BE_W-1:0]   fmt_be;
    logic [DATA_W-1:0] fmt_wdata;
    logic [DATA_W-1:0] fmt_ld;

    assign size_in     = mem_size_e'(size);
    assign one_op      = ReadMem ^ WriteMem;
    assign any_op      = ReadMem | WriteMem;
    assign size_ok     = (DATA_W == 64) || (size_in != SZ_DWORD);
    assign aligned     = is_aligned(size_in, addr[2:0]);
    assign can_accept  = (state_q != ST_REQ);
    assign accept      = can_accept & op_valid & one_op & size_ok & aligned;
    assign illegal     = can_accept & op_valid & any_op & ~(one_op & size_ok & aligned);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign st_data     = FWLS ? WB_data : reg_data_2;

    // Live inputs steer store lanes at accept; latched op fields format the read data.
    assign fmt_size = (state_q == ST_REQ) ? size_q : size_in;
    assign fmt_lane = (state_q == ST_REQ) ? lane_q : addr[LANE_W-1:0];
    assign fmt_sext = (state_q == ST_REQ) ? sext_q : sign_ext;

    mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
        .size    (fmt_size),
        .lane    (fmt_lane),
        .sign_ext(fmt_sext),
        .st_data (st_data),
        .rd_data (mem.mem_rdata),
        .be      (fmt_be),
        .wdata   (fmt_wdata),
        .ld_data (fmt_ld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        dtr_d   = dtr_q;
        size_d  = size_q;
        lane_d  = lane_q;
        sext_d  = sext_q;
        lv_d    = 1'b0;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = ST_REQ;
                    stall   = 1'b1;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = WriteMem;
                    addr_d  = {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                    be_d    = fmt_be;
                    wdata_d = WriteMem ? fmt_wdata : '0;
                    size_d  = size_in;
                    lane_d  = addr[LANE_W-1:0];
                    sext_d  = sign_ext;
                end else if (illegal) begin
                    aerr_d = 1'b1;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (mem.mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        dtr_d = fmt_ld;
                        lv_d  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    dtr_d   = '0;
                    berr_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            dtr_q   <= '0;
            size_q  <= SZ_BYTE;
            lane_q  <= '0;
            sext_q  <= 1'b0;
            lv_q    <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            dtr_q   <= dtr_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            sext_q  <= sext_d;
            lv_q    <= lv_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
    assign data_to_reg   = dtr_q;
    assign load_valid    = lv_q;
    assign addr_err      = aerr_q;
    assign bus_err       = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized ops checked against an arithmetic reference model.
module tb_mem_access_unit;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              rst;
    logic              op_valid;
    logic              ReadMem;
    logic              WriteMem;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic              FWLS;
    logic [DATA_W-1:0] reg_data_2;
    logic [DATA_W-1:0] WB_data;
    logic              stall;
    logic [DATA_W-1:0] data_to_reg;
    logic              load_valid;
    logic              addr_err;
    logic              bus_err;

    mem_access_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .ReadMem    (ReadMem),
        .WriteMem   (WriteMem),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .FWLS       (FWLS),
        .reg_data_2 (reg_data_2),
        .WB_data    (WB_data),
        .mem        (mif.master),
        .stall      (stall),
        .data_to_reg(data_to_reg),
        .load_valid (load_valid),
        .addr_err   (addr_err),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_dtr = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] rdat, input int nb, input int lane, input bit sx);
        longint unsigned v, m;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = ({32'd0, rdat} >> (8 * lane)) & m;
        if (sx && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int nb, input int lane);
        longint unsigned v, m;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = (({32'd0, d}) & m) << (8 * lane);
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_be(input int nb, input int lane);
        int v;
        v = ((1 << nb) - 1) << lane;
        return v[3:0];
    endfunction

    task automatic idle(input bit ack);
        op_valid = 1'b0; ReadMem = 1'b0; WriteMem = 1'b0;
        mif.mem_ack = ack; mif.mem_rdata = $urandom;
        #1;
        check_val("stall_idle", stall, 1'b0);
        step();
        mif.mem_ack = 1'b0;
        check_val("lv_idle", load_valid, 1'b0);
        check_val("aerr_idle", addr_err, 1'b0);
        check_val("berr_idle", bus_err, 1'b0);
        check_val("req_idle", mif.mem_req, 1'b0);
        check_val("dtr_hold", data_to_reg, exp_dtr);
    endtask

    // lat = number of REQ cycles until ack; outside 1..TIMEOUT means never acked.
    task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input bit fw, input logic [31:0] r2,
                         input logic [31:0] wb, input logic [31:0] rdat, input int lat);
        bit legal, any, ack_ok;
        int nb, lane, n;
        logic [31:0] sd;
        nb   = 1 << sz;
        lane = int'(a[1:0]);
        any  = rd | wr;
        legal = (rd ^ wr) && (sz != 2'd3) && ((a & (nb - 1)) == 0);
        sd   = fw ? wb : r2;
        op_valid = 1'b1; ReadMem = rd; WriteMem = wr; size = sz; sign_ext = sx;
        addr = a; FWLS = fw; reg_data_2 = r2; WB_data = wb;
        #1;
        check_val("stall_acc", stall, legal);
        step();
        op_valid = 1'b0; ReadMem = 1'b0; WriteMem = 1'b0;
        reg_data_2 = $urandom; WB_data = $urandom;
        if (!legal) begin
            check_val("addr_err", addr_err, any);
            check_val("req_ill", mif.mem_req, 1'b0);
            check_val("lv_ill", load_valid, 1'b0);
            return;
        end
        check_val("req_set", mif.mem_req, 1'b1);
        check_val("we", mif.mem_we, wr);
        check_val("maddr", mif.mem_addr, a & ~32'd3);
        check_val("aerr_acc", addr_err, 1'b0);
        if (wr) begin
            check_val("be", mif.mem_be, model_be(nb, lane));
            check_val("wdata", mif.mem_wdata, model_wdata(sd, nb, lane));
        end
        ack_ok = (lat >= 1) && (lat <= TIMEOUT);
        n = ack_ok ? lat : TIMEOUT;
        for (int k = 1; k <= n; k++) begin
            mif.mem_ack   = ack_ok && (k == n);
            mif.mem_rdata = mif.mem_ack ? rdat : $urandom;
            #1;
            check_val("stall_req", stall, 1'b1);
            check_val("req_hold", mif.mem_req, 1'b1);
            check_val("addr_hold", mif.mem_addr, a & ~32'd3);
            step();
            mif.mem_ack = 1'b0;
        end
        if (ack_ok && rd) exp_dtr = model_load(rdat, nb, lane, sx);
        else if (!ack_ok) exp_dtr = '0;
        check_val("req_done", mif.mem_req, 1'b0);
        check_val("lv_done", load_valid, ack_ok && rd);
        check_val("berr_done", bus_err, !ack_ok);
        check_val("aerr_done", addr_err, 1'b0);
        check_val("dtr", data_to_reg, exp_dtr);
    endtask

    initial begin
        rst = 1'b0; op_valid = 1'b0; ReadMem = 1'b0; WriteMem = 1'b0; size = 2'd0;
        sign_ext = 1'b0; addr = '0; FWLS = 1'b0; reg_data_2 = '0; WB_data = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        repeat (3) step();
        check_val("rst_req", mif.mem_req, 1'b0);
        check_val("rst_we", mif.mem_we, 1'b0);
        check_val("rst_addr", mif.mem_addr, 32'd0);
        check_val("rst_be", mif.mem_be, 4'd0);
        check_val("rst_wdata", mif.mem_wdata, 32'd0);
        check_val("rst_dtr", data_to_reg, 32'd0);
        check_val("rst_pulses", {load_valid, addr_err, bus_err}, 3'd0);
        check_val("rst_stall", stall, 1'b0);
        rst = 1'b1;
        idle(1'b1);

        // Directed scenarios
        do_op(1, 0, 2'd2, 0, 32'h104, 0, 0, 0, 32'hDEADBEEF, 3); idle(0);
        do_op(1, 0, 2'd0, 1, 32'h203, 0, 0, 0, 32'h80FFFF7F, 1); idle(0);
        do_op(1, 0, 2'd0, 0, 32'h203, 0, 0, 0, 32'h80FFFF7F, 2); idle(0);
        do_op(0, 1, 2'd1, 0, 32'h12, 1, 32'h11111111, 32'h0000ABCD, 0, 2); idle(0);
        do_op(1, 0, 2'd2, 0, 32'h102, 0, 0, 0, 0, 1); idle(0);
        do_op(1, 0, 2'd2, 1, 32'h300, 0, 0, 0, 0, 0); idle(1);
        do_op(1, 0, 2'd1, 1, 32'h40, 0, 0, 0, 32'h12348765, 1);
        do_op(1, 0, 2'd2, 0, 32'h44, 0, 0, 0, 32'hCAFEF00D, 1);
        do_op(0, 1, 2'd0, 0, 32'h45, 0, 32'h000000A5, 0, 0, 1);
        idle(0);

        // Reset while a load is outstanding; the late ack must be ignored.
        op_valid = 1'b1; ReadMem = 1'b1; WriteMem = 1'b0; size = 2'd2; addr = 32'h500;
        step();
        op_valid = 1'b0; ReadMem = 1'b0;
        check_val("rstreq_req", mif.mem_req, 1'b1);
        rst = 1'b0;
        step();
        exp_dtr = '0;
        check_val("rstreq_drop", mif.mem_req, 1'b0);
        check_val("rstreq_addr", mif.mem_addr, 32'd0);
        check_val("rstreq_dtr", data_to_reg, 32'd0);
        rst = 1'b1;
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h5555AAAA;
        #1;
        check_val("rstreq_stall", stall, 1'b0);
        step();
        mif.mem_ack = 1'b0;
        check_val("rstreq_lv", load_valid, 1'b0);
        check_val("rstreq_dtr2", data_to_reg, 32'd0);
        idle(0);

        // Randomized ops
        for (int i = 0; i < 150; i++) begin
            int kind, nbr;
            bit rd, wr;
            logic [1:0] sz;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            rd = (kind == 0) || (kind >= 2 && kind <= 5);
            wr = (kind == 0) || (kind >= 6);
            sz = 2'($urandom_range(0, 3));
            nbr = 1 << sz;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbr) - 32'd1);
            do_op(rd, wr, sz, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom, $urandom_range(1, 5));
            repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)));
        end
        idle(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the combinational MEM stage.
- Same store-data forwarding mux, store byte-lane steering and load extraction/sign-extension, generalised to DATA_W and byte/half/word/dword sizes.
- Adds a registered request/acknowledge handshake to a variable-latency data memory, with wait states, pipeline stall, misalignment detection and a bus timeout.
- Sits between EX/MEM and MEM/WB pipeline registers; drives the data-memory port directly.

Parameters:
- DATA_W, 32, data/register width; must be 32 or 64. BE_W = DATA_W/8.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, max cycles in REQ before bus error; 0 disables timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- op_valid  in  1  MEM-stage instruction carries a memory op this cycle.
- ReadMem  in  1  load.
- WriteMem  in  1  store.
- size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
- sign_ext  in  1  load result sign-extended when 1, zero-extended when 0.
- addr  in  ADDR_W  byte address.
- FWLS  in  1  store-data source: 0 reg_data_2, 1 WB_data.
- reg_data_2  in  DATA_W  store data from register file.
- WB_data  in  DATA_W  forwarded write-back data.
- mem_req  out  1  memory request (registered).
- mem_we  out  1  1 write, 0 read.
- mem_addr  out  ADDR_W  addr with low log2(BE_W) bits cleared.
- mem_be  out  BE_W  byte enables.
- mem_wdata  out  DATA_W  store data replicated/shifted into the selected lanes.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.
- stall  out  1  freeze upstream pipeline (combinational).
- data_to_reg  out  DATA_W  formatted load result (registered).
- load_valid  out  1  one-cycle pulse: data_to_reg valid.
- addr_err  out  1  one-cycle pulse: misaligned or illegal op.
- bus_err  out  1  one-cycle pulse: timeout.

Behaviour:
- Reset (rst=0 at edge): state IDLE; timeout counter 0; all outputs 0, including mem_req, mem_we, mem_addr, mem_be, mem_wdata, data_to_reg, load_valid, addr_err, bus_err. Reset mid-REQ drops mem_req at that edge; a late mem_ack is ignored.
- States: IDLE, REQ, DONE.
- Accept condition: state in {IDLE, DONE}, op_valid=1, exactly one of ReadMem/WriteMem set, address aligned to size, size legal for DATA_W.
- Illegal condition: ReadMem and WriteMem both set, misaligned address, or dword with DATA_W=32.
  - addr_err=1 next cycle; no request issued; no stall.
  - op_valid with neither ReadMem nor WriteMem is a no-op.
- On accept:
  - stall=1 in the accept cycle.
  - Next edge: state goes to REQ; mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and held stable until ack.
  - Store data is sampled through the FWLS mux at accept.
- REQ:
  - stall=1.
  - Counter increments each cycle. When mem_ack=1, go to DONE and clear mem_req on that edge.
  - For reads, data_to_reg is loaded on the same edge and load_valid=1 in DONE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without ack: mem_req=0, bus_err=1, data_to_reg=0, state goes to DONE.
- DONE: stall=0 for one cycle so the pipeline advances. A new op presented in DONE is accepted exactly as in IDLE (back-to-back ops, 2-cycle minimum per op with 0-wait memory). Otherwise return to IDLE.
- Load formatting:
  - Lane = addr[log2(BE_W)-1:0].
  - Extract 8/16/32/64 bits from that lane, then sign- or zero-extend to DATA_W.
- Store formatting:
  - mem_be has 1,2,4 or 8 contiguous bits set at the lane.
  - Data is shifted left by 8×lane; unselected lanes are don't-care and driven 0.
- mem_ack while in IDLE or DONE is ignored.
- load_valid, addr_err and bus_err are mutually exclusive single-cycle pulses.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD;
  - state encodings;
  - width defines (RegDataWidth, ByteSlctWidth generalised to BE_W).
- Natural sub-module: mem_lane_fmt, pure combinational. It takes size, lane, sign_ext, store data and read data, and produces be, wdata and the extended load value. The FSM and handshake stay in mem_access_unit.

Test Plan:
- Word load, addr=0x104, mem_ack 3 cycles after mem_req, mem_rdata=0xDEADBEEF → mem_addr=0x104, mem_be=4'b1111, stall high 4 cycles, load_valid pulse, data_to_reg=0xDEADBEEF.
- Byte load, signed, addr=0x203, mem_rdata=0x80FFFF7F → mem_be ignored for read, data_to_reg=0xFFFFFF80; repeat unsigned → 0x00000080.
- Half store with FWLS=1, WB_data=0x0000ABCD, reg_data_2=0x11111111, addr=0x12 → mem_be=4'b1100, mem_wdata=0xABCD0000, mem_we=1.
- Misaligned word load, addr=0x102 → addr_err pulse next cycle, mem_req never asserted, stall=0.
- TIMEOUT=4, no ack → mem_req drops after 4 REQ cycles, bus_err pulse, data_to_reg=0, pipeline released.
- rst=0 asserted during REQ → next edge mem_req=0, state IDLE, later mem_ack produces no load_valid; back-to-back loads with 0-wait ack accepted in DONE.
